da_engine_p: RTL and testbench
==============================

# da_engine_p

Parametrised distributed-arithmetic (DA) MAC engine for the FIR datapath. It replaces the fixed 8-bank, hand-sequenced adder chain with three pieces: a configurable number of LUT banks, a pipelined registered adder tree, and a bit-serial shift-accumulator with two's-complement sign handling. The engine drives the bit-plane index to an external coefficient-LUT bank (sram_8blk-style) and consumes its flattened outputs. It returns one filter output per start using a valid/ready result handshake.

## Interface
- NBANK, 8: LUT banks summed per bit-plane. Power of two, ≥2. L = log2(NBANK) tree stages.
- CW, 20: signed LUT word width.
- BW, 16: input sample bits, i.e. number of bit-planes, ≥2.
- ROM_LAT, 1: cycles from `plane`/`rd_en` to valid `q`, 0..3.
- RS, 15: right shift applied when DA_ROUND_EN is set.
- OW, 24: rounded output width when DA_ROUND_EN is set.
- clk  in  1  clock; all state on rising edge.
- resetn  in  1  reset; synchronous, active-low.
- start  in  1  request one computation; accepted only when `in_ready`=1.
- in_ready  out  1  high only in IDLE.
- rd_en  out  1  LUT read strobe; high during RUN.
- plane  out  log2(BW)  bit-plane index driven to the LUT address mux, MSB-first.
- q  in  NBANK*CW  flattened LUT outputs; bank i occupies bits [i*CW +: CW].
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  RW  signed result. RW = OW with DA_ROUND_EN, otherwise AW = CW+L+BW.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on `start`. In the same edge, acc is cleared and the plane counter is loaded with BW-1.
- RUN issues one plane per cycle, BW-1 down to 0, with `rd_en`=1.
  - Transition to DRAIN after plane 0 is issued.
- DRAIN waits until the last tagged tree output has been accumulated, then goes to DONE.
- DONE holds `out_valid`=1 with `result` stable. Go to IDLE on `out_valid & out_ready`.
- Valid pipeline:
  - A ROM_LAT+L-deep shift register carries {valid, msb} tags alongside the data.
  - msb=1 only for plane BW-1.
- Adder tree:
  - Stage s adds adjacent pairs.
  - Each operand is sign-extended by one bit per stage, so the stage output is CW+s bits.
  - Every stage is registered. Final sum T is CW+L bits.
- Accumulate on each tagged-valid tree output, with T sign-extended to AW:
  - acc ← (acc<<1) − T when msb=1;
  - acc ← (acc<<1) + T otherwise.
  - Result is exact signed Σ coefficient·sample; no overflow is possible in AW bits.
- `start` is ignored outside IDLE.
- `q` is ignored except in its tagged-valid cycles.
- Reset mid-operation aborts the computation and discards all pipeline contents.

## Timing
- Start accepted at edge E. First RUN cycle is cycle 0.
- Plane k (issued in cycle BW-1-k) is visible on `q` ROM_LAT cycles later and enters acc L cycles after that.
- `out_valid` first high in cycle BW+ROM_LAT+L.
  - Defaults: cycle 20 after E.
- Back-to-back throughput: the next start can be accepted in the cycle after the handshake. Minimum period is BW+ROM_LAT+L+2 cycles.
- Reset values:
  - in_ready=1 (IDLE);
  - rd_en=0, plane=0, out_valid=0, result=0;
  - acc, tree registers and tags all zero.

## Configuration
- DA_ROUND_EN defined:
  - result = saturate_OW((acc + 2^(RS-1)) >>> RS), i.e. round half up.
  - Clamps to [−2^(OW-1), 2^(OW-1)−1].
  - Rounding/saturation is combinational from the acc register; no added latency.
- DA_ROUND_EN undefined: result = full-width acc, AW bits, no rounding logic.

## Structure
- Package da_pkg:
  - state enum (IDLE/RUN/DRAIN/DONE);
  - clog2 function;
  - derived-width constants L, AW, PW = log2(BW).
- One sub-module, da_adder_tree (NBANK, CW): generate-built registered tree plus the tag pipeline.
- FSM, plane counter, ROM-latency tag delay, accumulator and output stage all live in the top.

## Test plan
- Reset then `q`=0 for all planes → after start, `out_valid` at cycle 20 with result=0; `in_ready` low cycles 0–20.
- All 8 banks = 1 on every plane, defaults, no macro → result = −8·2^15 + 8·(2^15−1) = −8.
- Bench LUT model returns bank0=100 on plane 0 only, all else 0 → result=100. Bank0=1 on plane 15 only → result=−32768.
- Hold `out_ready` low 5 cycles in DONE, pulsing `start` → result stable, `start` ignored, `in_ready`=0. Handshake, then an immediate second start is accepted the next cycle.
- Assert resetn=0 in cycle 7 of RUN → next cycle all outputs at reset values. A fresh start then yields the correct result with no residue from the aborted run.
- DA_ROUND_EN, acc=49152 → result=2. acc=2^38−1 with OW=24 → result=2^23−1 (saturated).

Source files
------------

// File: rtl/da_pkg.sv
// Shared types and width helpers for the distributed-arithmetic MAC engine.
package da_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Ceiling log2, usable in parameter and port declarations.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Exact accumulator width: LUT word, adder-tree growth, one bit per plane.
    function automatic int acc_width(input int nbank, input int cw, input int bw);
        return cw + clog2(nbank) + bw;
    endfunction

endpackage

// File: rtl/da_adder_tree.sv
// Registered pairwise adder tree over NBANK signed LUT words, with a {valid, msb}
// tag pipeline that travels alongside the data so the accumulator knows what to do.
module da_adder_tree
    import da_pkg::*;
#(
    parameter  int NBANK = 8,
    parameter  int CW    = 20,
    localparam int L     = clog2(NBANK)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NBANK*CW-1:0]   data_i,
    input  logic                  vld_i,
    input  logic                  msb_i,
    output logic [CW+L-1:0]       sum_o,
    output logic                  vld_o,
    output logic                  msb_o
);

    // Stage s holds NBANK>>s nodes of CW+s bits; stage 0 is the unpacked input bus.
    for (genvar s = 0; s <= L; s++) begin : g_stg
        logic signed [CW+s-1:0] node [NBANK>>s];

        if (s == 0) begin : g_leaf
            for (genvar j = 0; j < NBANK; j++) begin : g_bank
                assign node[j] = data_i[j*CW +: CW];
            end
        end else begin : g_add
            // NOTE: the tree registers take the synchronous reset too, so an aborted
            // run can never leak a partial sum into the next computation.
            always_ff @(posedge clk) begin
                for (int j = 0; j < (NBANK >> s); j++) begin
                    if (!resetn) begin
                        node[j] <= '0;
                    end else begin
                        node[j] <= {g_stg[s-1].node[2*j][CW+s-2],   g_stg[s-1].node[2*j]}
                                 + {g_stg[s-1].node[2*j+1][CW+s-2], g_stg[s-1].node[2*j+1]};
                    end
                end
            end
        end
    end

    logic [L-1:0] vld_q;
    logic [L-1:0] msb_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_q <= '0;
            msb_q <= '0;
        end else begin
            vld_q[0] <= vld_i;
            msb_q[0] <= msb_i;
            for (int i = 1; i < L; i++) begin
                vld_q[i] <= vld_q[i-1];
                msb_q[i] <= msb_q[i-1];
            end
        end
    end

    assign sum_o = g_stg[L].node[0];
    assign vld_o = vld_q[L-1];
    assign msb_o = msb_q[L-1];

endmodule

// File: rtl/da_engine_p.sv
// DA MAC engine: MSB-first plane sequencer, LUT-latency tag delay, adder tree and
// two's-complement shift-accumulator. Define DA_ROUND_EN for round/saturate to OW bits.
module da_engine_p
    import da_pkg::*;
#(
    parameter  int NBANK   = 8,
    parameter  int CW      = 20,
    parameter  int BW      = 16,
    parameter  int ROM_LAT = 1,
`ifdef DA_ROUND_EN
    parameter  int RS      = 15,
    parameter  int OW      = 24,
`endif
    localparam int L       = clog2(NBANK),
    localparam int AW      = acc_width(NBANK, CW, BW),
    localparam int PW      = clog2(BW),
`ifdef DA_ROUND_EN
    localparam int RW      = OW
`else
    localparam int RW      = AW
`endif
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    output logic                 in_ready,
    output logic                 rd_en,
    output logic [PW-1:0]        plane,
    input  logic [NBANK*CW-1:0]  q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RW-1:0]        result
);

    state_e            state_q;
    logic              in_ready_q;
    logic              rd_en_q;
    logic              out_valid_q;
    logic [PW-1:0]     plane_q;
    logic [PW-1:0]     cnt_q;
    logic [AW-1:0]     acc_q;
    logic [AW-1:0]     acc_d;

    logic              issue_msb;
    logic              tag_vld;
    logic              tag_msb;
    logic [CW+L-1:0]   t_sum;
    logic              t_vld;
    logic              t_msb;
    logic [AW-1:0]     t_ext;

    assign issue_msb = rd_en_q && (plane_q == PW'(BW - 1));

    // Delay the issue tags by ROM_LAT so they line up with the matching q word.
    if (ROM_LAT == 0) begin : g_no_lat
        assign tag_vld = rd_en_q;
        assign tag_msb = issue_msb;
    end else begin : g_lat
        logic [ROM_LAT-1:0] vld_q;
        logic [ROM_LAT-1:0] msb_q;

        always_ff @(posedge clk) begin
            if (!resetn) begin
                vld_q <= '0;
                msb_q <= '0;
            end else begin
                vld_q[0] <= rd_en_q;
                msb_q[0] <= issue_msb;
                for (int i = 1; i < ROM_LAT; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    msb_q[i] <= msb_q[i-1];
                end
            end
        end

        assign tag_vld = vld_q[ROM_LAT-1];
        assign tag_msb = msb_q[ROM_LAT-1];
    end

    da_adder_tree #(
        .NBANK (NBANK),
        .CW    (CW)
    ) u_tree (
        .clk    (clk),
        .resetn (resetn),
        .data_i (q),
        .vld_i  (tag_vld),
        .msb_i  (tag_msb),
        .sum_o  (t_sum),
        .vld_o  (t_vld),
        .msb_o  (t_msb)
    );

    assign t_ext = {{BW{t_sum[CW+L-1]}}, t_sum};

    // The sample's sign plane carries weight -2^(BW-1), hence the subtraction.
    always_comb begin
        acc_d = acc_q;
        if (t_vld) begin
            if (t_msb) acc_d = {acc_q[AW-2:0], 1'b0} - t_ext;
            else       acc_d = {acc_q[AW-2:0], 1'b0} + t_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            rd_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            plane_q     <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
        end else begin
            acc_q <= acc_d;
            if (t_vld) cnt_q <= cnt_q + 1'b1;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        rd_en_q    <= 1'b1;
                        plane_q    <= PW'(BW - 1);
                        cnt_q      <= '0;
                        acc_q      <= '0;
                    end
                end
                RUN: begin
                    if (plane_q == '0) begin
                        state_q <= DRAIN;
                        rd_en_q <= 1'b0;
                    end else begin
                        plane_q <= plane_q - 1'b1;
                    end
                end
                DRAIN: begin
                    // Leave on the same edge that folds in the final plane.
                    if (t_vld && (cnt_q == PW'(BW - 1))) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign rd_en     = rd_en_q;
    assign plane     = plane_q;
    assign out_valid = out_valid_q;

`ifdef DA_ROUND_EN
    localparam logic signed [AW:0] HALF = (AW+1)'(1) << (RS - 1);
    localparam logic signed [AW:0] MAXV = {{(AW-OW+2){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW:0] MINV = ~MAXV;

    logic signed [AW:0] acc_x;
    logic signed [AW:0] acc_rnd;

    // One guard bit keeps the half-LSB addition from wrapping near full scale.
    always_comb begin
        acc_x   = {acc_q[AW-1], acc_q};
        acc_rnd = (acc_x + HALF) >>> RS;
        if (acc_rnd > MAXV)      result = MAXV[OW-1:0];
        else if (acc_rnd < MINV) result = MINV[OW-1:0];
        else                     result = acc_rnd[OW-1:0];
    end
`else
    assign result = acc_q;
`endif

endmodule

// File: tb/tb_da_engine_p.sv
// Self-checking bench for da_engine_p: LUT model on q, table vectors, random LUTs, corner sequences.
module tb_da_engine_p;

    localparam int NBANK   = 8;
    localparam int CW      = 20;
    localparam int BW      = 16;
    localparam int ROM_LAT = 1;
    localparam int L       = 3;
    localparam int AW      = CW + L + BW;
`ifdef DA_ROUND_EN
    localparam int RS      = 15;
    localparam int OW      = 24;
    localparam int RW      = OW;
`else
    localparam int RW      = AW;
`endif
    localparam int LAT     = BW + ROM_LAT + L;

    logic                    clk = 1'b0;
    logic                    resetn = 1'b0;
    logic                    start = 1'b0;
    logic                    out_ready = 1'b0;
    logic                    in_ready;
    logic                    rd_en;
    logic [3:0]              plane;
    logic [NBANK*CW-1:0]     q;
    logic                    out_valid;
    logic signed [RW-1:0]    result;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint lut [BW][NBANK];

    always #5 clk = ~clk;

    da_engine_p dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .in_ready  (in_ready),
        .rd_en     (rd_en),
        .plane     (plane),
        .q         (q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    // External coefficient LUT with one cycle of read latency; junk when not read.
    always @(posedge clk) begin
        for (int i = 0; i < NBANK; i++) begin
            q[i*CW +: CW] <= rd_en ? CW'(lut[plane][i]) : CW'($urandom);
        end
    end

    task automatic check(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic longint fin(input longint e);
`ifdef DA_ROUND_EN
        longint r;
        longint hi;
        r  = (e + (longint'(1) << (RS - 1))) >>> RS;
        hi = (longint'(1) << (OW - 1)) - 1;
        if (r > hi) return hi;
        if (r < -hi - 1) return -hi - 1;
        return r;
`else
        return e;
`endif
    endfunction

    // Sum over planes of (bank sum) * plane weight; the top plane weighs -2^(BW-1).
    function automatic longint model();
        longint s;
        longint ps;
        s = 0;
        for (int k = 0; k < BW; k++) begin
            ps = 0;
            for (int i = 0; i < NBANK; i++) ps += lut[k][i];
            if (k == BW - 1) s -= ps * (longint'(1) << k);
            else             s += ps * (longint'(1) << k);
        end
        return fin(s);
    endfunction

    task automatic set_lut(input longint fill, input longint msbv,
                           input int bank, input int pl, input longint val);
        for (int k = 0; k < BW; k++)
            for (int i = 0; i < NBANK; i++)
                lut[k][i] = (k == BW - 1) ? msbv : fill;
        if (bank >= 0) lut[pl][bank] = val;
    endtask

    task automatic rand_lut();
        for (int k = 0; k < BW; k++)
            for (int i = 0; i < NBANK; i++)
                lut[k][i] = longint'($urandom_range(0, (1 << CW) - 1)) - (longint'(1) << (CW - 1));
    endtask

    // Wait for in_ready, pulse start; returns at the negedge of RUN cycle 0.
    task automatic kick(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) check({name, "/in_ready_timeout"}, 0, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts cycles from the current one until out_valid; flags in_ready seen high.
    task automatic wait_valid(output int n, output bit ready_seen);
        n = 0;
        ready_seen = 1'b0;
        while (!out_valid && n < 200) begin
            if (in_ready) ready_seen = 1'b1;
            n++;
            @(negedge clk);
        end
        if (in_ready) ready_seen = 1'b1;
    endtask

    task automatic run(input string name, input longint exp, input bit chk_lat);
        int n;
        bit rs;
        kick(name);
        wait_valid(n, rs);
        check({name, "/valid"}, out_valid, 1);
        if (chk_lat) begin
            check({name, "/latency"}, n, LAT);
            check({name, "/in_ready_low"}, rs, 0);
        end
        check({name, "/result"}, longint'(result), exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        string  name;
        longint fill;
        longint msbv;
        int     bank;
        int     pl;
        longint val;
        longint exact;
    } vec_t;

    vec_t vt [8];

    initial begin
        vt[0] = '{"zero",      0,       0,       -1, 0,  0,   0};
        vt[1] = '{"all_ones",  1,       1,       -1, 0,  0,   -8};
        vt[2] = '{"b0_p0_100", 0,       0,       0,  0,  100, 100};
        vt[3] = '{"b0_p15_1",  0,       0,       0,  15, 1,   -32768};
        vt[4] = '{"b3_p14_3",  0,       0,       3,  14, 3,   49152};
        vt[5] = '{"b7_p3_m5",  0,       0,       7,  3,  -5,  -40};
        vt[6] = '{"max_pos",   524287,  -524288, -1, 0,  0,
                  longint'(8) * 524288 * 32768 + longint'(8) * 524287 * 32767};
        vt[7] = '{"max_neg",   -524288, 524287,  -1, 0,  0,
                  -(longint'(8) * 524287 * 32768) - longint'(8) * 524288 * 32767};

        set_lut(0, 0, -1, 0, 0);
        repeat (3) @(negedge clk);
        check("reset/in_ready",  in_ready, 1);
        check("reset/rd_en",     rd_en, 0);
        check("reset/plane",     plane, 0);
        check("reset/out_valid", out_valid, 0);
        check("reset/result",    longint'(result), 0);
        resetn = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            set_lut(vt[v].fill, vt[v].msbv, vt[v].bank, vt[v].pl, vt[v].val);
            run(vt[v].name, fin(vt[v].exact), 1'b1);
        end

        for (int r = 0; r < 16; r++) begin
            rand_lut();
            run($sformatf("rand%0d", r), model(), r < 2);
        end

        // Hold DONE with out_ready low while poking start, then chain a second run.
        begin
            longint exp1;
            longint exp2;
            int     n;
            bit     rs;
            rand_lut();
            exp1 = model();
            kick("hold");
            wait_valid(n, rs);
            check("hold/valid", out_valid, 1);
            for (int c = 0; c < 5; c++) begin
                start = (c % 2 == 0);
                @(negedge clk);
                check("hold/result",    longint'(result), exp1);
                check("hold/in_ready",  in_ready, 0);
                check("hold/out_valid", out_valid, 1);
            end
            rand_lut();
            exp2 = model();
            start = 1'b1;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("chain/idle_in_ready", in_ready, 1);
            check("chain/idle_valid",    out_valid, 0);
            @(negedge clk);
            start = 1'b0;
            check("chain/accepted",  in_ready, 0);
            check("chain/rd_en",     rd_en, 1);
            check("chain/plane",     plane, BW - 1);
            wait_valid(n, rs);
            check("chain/latency",   n, LAT);
            check("chain/result",    longint'(result), exp2);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end

        // Abort in RUN cycle 7; the following run must carry no residue.
        rand_lut();
        kick("abort");
        repeat (7) @(negedge clk);
        check("abort/in_run", rd_en, 1);
        resetn = 1'b0;
        @(negedge clk);
        check("abort/in_ready",  in_ready, 1);
        check("abort/rd_en",     rd_en, 0);
        check("abort/plane",     plane, 0);
        check("abort/out_valid", out_valid, 0);
        check("abort/result",    longint'(result), 0);
        resetn = 1'b1;
        @(negedge clk);
        set_lut(0, 0, 2, 5, 7);
        run("after_abort", fin(longint'(7) * 32), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
